// File: rtl/bypass_scoreboard_ex_if.sv
// Operand/forwarding/scoreboard signal bundle for bypass_scoreboard_ex.
// master drives the pipeline side, slave is the bypass block itself.
interface bypass_scoreboard_ex_if #(
  parameter int XLEN  = 32,
  parameter int NSRC  = 2,
  parameter int NFWD  = 2,
  parameter int CNT_W = 16
);
  logic                 flush;
  logic [NSRC*5-1:0]    src_addr;
  logic [NSRC*XLEN-1:0] src_data;
  logic [NSRC-1:0]      src_use;
  logic                 issue_valid;
  logic                 issue_long;
  logic [4:0]           issue_rd;
  logic [NFWD-1:0]      fwd_valid;
  logic [NFWD*5-1:0]    fwd_rd;
  logic [NFWD*XLEN-1:0] fwd_data;
  logic                 lr_valid;
  logic [4:0]           lr_rd;
  logic [XLEN-1:0]      lr_data;
  logic [NSRC*XLEN-1:0] op_out;
  logic                 stall;
  logic [31:0]          busy_vec;
  logic [CNT_W-1:0]     stall_cnt;

  modport master (
    output flush, src_addr, src_data, src_use,
    output issue_valid, issue_long, issue_rd,
    output fwd_valid, fwd_rd, fwd_data,
    output lr_valid, lr_rd, lr_data,
    input  op_out, stall, busy_vec, stall_cnt
  );

  modport slave (
    input  flush, src_addr, src_data, src_use,
    input  issue_valid, issue_long, issue_rd,
    input  fwd_valid, fwd_rd, fwd_data,
    input  lr_valid, lr_rd, lr_data,
    output op_out, stall, busy_vec, stall_cnt
  );
endinterface

// File: rtl/bypass_scoreboard_ex.sv
// EX-stage operand bypass with a long-latency scoreboard, stall generation and
// capture of forwarded operands that must outlive their producer during a stall.
module bypass_scoreboard_ex #(
  parameter int XLEN  = 32,
  parameter int NSRC  = 2,
  parameter int NFWD  = 2,
  parameter int CNT_W = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  bypass_scoreboard_ex_if.slave bus
);

  logic [31:0]          busy_q, busy_d;
  logic [NSRC-1:0]      cap_valid_q, cap_valid_d;
  logic [NSRC*XLEN-1:0] cap_data_q, cap_data_d;
  logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;

  logic [NSRC-1:0]      hit_s;
  logic [NSRC*XLEN-1:0] hit_data_s;
  logic [NSRC-1:0]      need_s;
  logic [NSRC*XLEN-1:0] op_s;
  logic                 stall_s;

  // Per-operand resolution: youngest forwarding stage, then the long-result port, then capture.
  always_comb begin : resolve
    logic [4:0] addr;
    logic       found;
    logic       lr_hit;
    hit_s      = '0;
    hit_data_s = '0;
    need_s     = '0;
    op_s       = '0;
    addr       = 5'd0;
    found      = 1'b0;
    lr_hit     = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      addr   = bus.src_addr[i*5 +: 5];
      found  = 1'b0;
      lr_hit = 1'b0;
      op_s[i*XLEN +: XLEN] = bus.src_data[i*XLEN +: XLEN];
      if (bus.src_use[i] && (addr != 5'd0)) begin
        for (int k = 0; k < NFWD; k++) begin
          if (!found && bus.fwd_valid[k] && (bus.fwd_rd[k*5 +: 5] == addr)) begin
            found = 1'b1;
            hit_data_s[i*XLEN +: XLEN] = bus.fwd_data[k*XLEN +: XLEN];
          end else begin
            found = found;
          end
        end
        lr_hit = bus.lr_valid && (bus.lr_rd == addr);
        if (!found && lr_hit) begin
          found = 1'b1;
          hit_data_s[i*XLEN +: XLEN] = bus.lr_data;
        end else begin
          found = found;
        end
        hit_s[i]  = found;
        // A result returning this very cycle is bypassed rather than waited for.
        need_s[i] = busy_q[addr] && !lr_hit;
        if (found) begin
          op_s[i*XLEN +: XLEN] = hit_data_s[i*XLEN +: XLEN];
        end else if (cap_valid_q[i]) begin
          op_s[i*XLEN +: XLEN] = cap_data_q[i*XLEN +: XLEN];
        end else begin
          op_s[i*XLEN +: XLEN] = bus.src_data[i*XLEN +: XLEN];
        end
      end else begin
        hit_s[i]  = 1'b0;
        need_s[i] = 1'b0;
      end
    end
    stall_s = |need_s;
  end

  // Next-state for scoreboard, capture registers and the stall counter.
  always_comb begin : next_state
    busy_d      = busy_q;
    cap_valid_d = cap_valid_q;
    cap_data_d  = cap_data_q;
    stall_cnt_d = stall_cnt_q;
    if (bus.lr_valid) begin
      busy_d[bus.lr_rd] = 1'b0;
    end else begin
      busy_d = busy_d;
    end
    // Set is applied after clear so a same-register set/clear leaves the bit pending.
    if (bus.issue_valid && bus.issue_long && (bus.issue_rd != 5'd0) && !stall_s) begin
      busy_d[bus.issue_rd] = 1'b1;
    end else begin
      busy_d = busy_d;
    end
    busy_d[0] = 1'b0;
    if (bus.flush) begin
      busy_d      = '0;
      cap_valid_d = '0;
    end else if (stall_s) begin
      for (int i = 0; i < NSRC; i++) begin
        if (hit_s[i]) begin
          cap_valid_d[i]             = 1'b1;
          cap_data_d[i*XLEN +: XLEN] = hit_data_s[i*XLEN +: XLEN];
        end else begin
          cap_valid_d[i] = cap_valid_q[i];
        end
      end
    end else begin
      cap_valid_d = '0;
    end
    if (stall_s && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_q      <= '0;
      cap_valid_q <= '0;
      cap_data_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      busy_q      <= busy_d;
      cap_valid_q <= cap_valid_d;
      cap_data_q  <= cap_data_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.op_out    = op_s;
  assign bus.stall     = stall_s;
  assign bus.busy_vec  = busy_q;
  assign bus.stall_cnt = stall_cnt_q;

endmodule
